// File: rtl/load_ctrl_pkg.sv
// Shared types for the program-load sequencer.
// State encoding and byte-address shift used by prog_load_ctrl.
package load_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } load_state_t;

    localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/prog_load_ctrl.sv
// Program loader: streams words into processor BRAM, then runs the core.
// Optional LOAD_CTRL_CHECKSUM_EN adds a running sum of accepted words.
module prog_load_ctrl
    import load_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 256,
    parameter int NUM_COL = 4,
    parameter int CYC_W   = 32,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CYC_W-1:0]   run_cycles,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_last,
    output logic [WIDTH-1:0]   bram_din,
    output logic [LOGSIZE+2:0] shared_bram_addr,
    output logic [NUM_COL-1:0] bram_wr_en,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LOGSIZE:0]   word_count,
    output logic [WIDTH-1:0]   checksum
);

    localparam logic [LOGSIZE:0] LAST_IDX = (LOGSIZE+1)'(SIZE - 1);

    load_state_t      state, state_n;
    logic [CYC_W-1:0] run_cyc;
    logic [CYC_W-1:0] cnt;
    logic             hs;
    logic             start_acc;
    logic             ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        hs         = (state == LOAD) && s_valid && !abort;
        start_acc  = (state == IDLE || state == DONE) && start && !abort;
        ovf        = hs && !s_last && (word_count == LAST_IDX);
        s_ready    = (state == LOAD);
        busy       = (state == LOAD) || (state == RUN);
        done       = (state == DONE);
        // First RUN cycle (cnt==0) presents the final write under reset
        core_reset = !((state == RUN) && (cnt != '0));
        unique case (state)
            IDLE, DONE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (hs && s_last)
                    state_n = (run_cyc != '0) ? RUN : DONE;
                else if (ovf)
                    state_n = DONE;
            end
            RUN: begin
                if (cnt == run_cyc) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_din         <= '0;
            shared_bram_addr <= '0;
            bram_wr_en       <= '0;
            word_count       <= '0;
            err              <= 1'b0;
            run_cyc          <= '0;
            cnt              <= '0;
        end else begin
            bram_wr_en <= '0;
            if (hs) begin
                bram_wr_en       <= '1;
                bram_din         <= s_data;
                shared_bram_addr <=
                    (LOGSIZE+3)'(word_count) << ADDR_SHIFT;
                word_count       <= word_count + 1'b1;
            end
            if (ovf) err <= 1'b1;
            if (start_acc) begin
                word_count <= '0;
                err        <= 1'b0;
                run_cyc    <= run_cycles;
            end
            if (state == RUN && state_n == RUN) cnt <= cnt + 1'b1;
            else                                cnt <= '0;
        end
    end

`ifdef LOAD_CTRL_CHECKSUM_EN
    logic [WIDTH-1:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  sum <= '0;
        else if (start_acc || abort) sum <= '0;
        else if (hs)                 sum <= sum + s_data;
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl (SIZE=8).
// Checks writes, run length, overflow, abort and async reset.
module tb_prog_load_ctrl;

    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int LS    = $clog2(SIZE);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [31:0]       run_cycles = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WIDTH-1:0]  s_data = '0;
    logic              s_last = 1'b0;
    logic [WIDTH-1:0]  bram_din;
    logic [LS+2:0]     shared_bram_addr;
    logic [3:0]        bram_wr_en;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [LS:0]       word_count;
    logic [WIDTH-1:0]  checksum;

    int tests = 0;
    int fails = 0;
    int low_cnt;
    int pulses;

    prog_load_ctrl #(
        .WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(4), .CYC_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .run_cycles(run_cycles), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .bram_din(bram_din), .shared_bram_addr(shared_bram_addr),
        .bram_wr_en(bram_wr_en), .core_reset(core_reset),
        .busy(busy), .done(done), .err(err),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] rc);
        start = 1'b1;
        run_cycles = rc;
        tick();
        start = 1'b0;
        chk("s_ready_after_start", 64'(s_ready), 64'd1);
    endtask

    task automatic push(input string tag, input logic [31:0] d,
                        input logic last, input int idx);
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        chk({tag, "_wr_en"}, 64'(bram_wr_en), 64'hF);
        chk({tag, "_addr"}, 64'(shared_bram_addr), 64'(idx * 4));
        chk({tag, "_din"}, 64'(bram_din), 64'(d));
    endtask

    task automatic run_to_done(input string tag);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) break;
            if (!core_reset) low_cnt++;
            if (bram_wr_en != 4'h0) pulses++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef LOAD_CTRL_CHECKSUM_EN
        return s;
`else
        return 32'(s & 32'h0);
`endif
    endfunction

    initial begin
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_wr_en", 64'(bram_wr_en), 64'd0);
        chk("rst_addr", 64'(shared_bram_addr), 64'd0);
        chk("rst_din", 64'(bram_din), 64'd0);
        chk("rst_busy_done_err", {busy, done, err}, 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        #10 reset = 1'b0;
        tick();

        // basic load + 10-cycle run
        do_start(32'd10);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_core_reset_load", 64'(core_reset), 64'd1);
        push("t1_w0", 32'h11, 1'b0, 0);
        push("t1_w1", 32'h22, 1'b0, 1);
        push("t1_w2", 32'h33, 1'b0, 2);
        push("t1_w3", 32'h44, 1'b1, 3);
        chk("t1_last_in_reset", 64'(core_reset), 64'd1);
        chk("t1_s_ready_off", 64'(s_ready), 64'd0);
        pulses = 0;
        run_to_done("t1");
        chk("t1_low_cycles", 64'(low_cnt), 64'd10);
        chk("t1_no_run_writes", 64'(pulses), 64'd0);
        chk("t1_word_count", 64'(word_count), 64'd4);
        chk("t1_checksum", 64'(checksum), 64'(exp_sum(32'hAA)));
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_core_reset_done", 64'(core_reset), 64'd1);

        // gapped stream from DONE
        do_start(32'd10);
        push("t2_w0", 32'h11, 1'b0, 0);
        tick();
        chk("t2_gap0", 64'(bram_wr_en), 64'd0);
        push("t2_w1", 32'h22, 1'b0, 1);
        tick();
        chk("t2_gap1", 64'(bram_wr_en), 64'd0);
        push("t2_w2", 32'h33, 1'b0, 2);
        tick();
        chk("t2_gap2", 64'(bram_wr_en), 64'd0);
        push("t2_w3", 32'h44, 1'b1, 3);
        pulses = 0;
        run_to_done("t2");
        chk("t2_no_extra_wr", 64'(pulses), 64'd0);
        chk("t2_word_count", 64'(word_count), 64'd4);
        chk("t2_checksum", 64'(checksum), 64'(exp_sum(32'hAA)));

        // overflow: SIZE words without last
        do_start(32'd5);
        for (int i = 0; i < SIZE; i++) begin
            push("t3_w", 32'(i + 1), 1'b0, i);
            chk("t3_core_reset", 64'(core_reset), 64'd1);
        end
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_word_count", 64'(word_count), 64'd8);
        chk("t3_s_ready", 64'(s_ready), 64'd0);
        chk("t3_checksum", 64'(checksum), 64'(exp_sum(32'h24)));
        tick();
        chk("t3_stays_reset", 64'(core_reset), 64'd1);

        // run_cycles=0: straight to DONE
        do_start(32'd0);
        chk("t4_err_cleared", 64'(err), 64'd0);
        push("t4_w0", 32'hDEAD_BEEF, 1'b1, 0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_core_reset", 64'(core_reset), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_word_count", 64'(word_count), 64'd1);
        tick();
        chk("t4_one_write", 64'(bram_wr_en), 64'd0);

        // abort on third handshake
        do_start(32'd10);
        push("t5_w0", 32'h5, 1'b0, 0);
        push("t5_w1", 32'h6, 1'b0, 1);
        s_valid = 1'b1;
        s_data = 32'h7;
        abort = 1'b1;
        tick();
        s_valid = 1'b0;
        abort = 1'b0;
        chk("t5_no_write", 64'(bram_wr_en), 64'd0);
        chk("t5_idle", {busy, done, s_ready}, 64'd0);
        chk("t5_word_count", 64'(word_count), 64'd2);
        chk("t5_checksum_clr", 64'(checksum), 64'd0);
        do_start(32'd0);
        push("t5_reload", 32'h9, 1'b1, 0);
        chk("t5_reload_done", 64'(done), 64'd1);

        // async reset mid-run
        do_start(32'd10);
        push("t6_w0", 32'hAB, 1'b1, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_running", 64'(core_reset), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_core_reset", 64'(core_reset), 64'd1);
        chk("t6_flags", {busy, done, err, s_ready}, 64'd0);
        chk("t6_word_count", 64'(word_count), 64'd0);
        chk("t6_addr_din", {32'(shared_bram_addr), bram_din}, 64'd0);
        chk("t6_wr_en", 64'(bram_wr_en), 64'd0);
        chk("t6_checksum", 64'(checksum), 64'd0);
        #10 reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
